// File: rtl/shift_reg_pkg.sv
// Shared mode and state encodings for the universal shift register.
package shift_reg_pkg;
  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROTL  = 3'b100;
  localparam logic [2:0] MODE_ROTR  = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Shift/rotate modes are the ones that make sense to repeat in a burst.
  function automatic logic is_shift(input logic [2:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ASR);
  endfunction
endpackage

// File: rtl/shift_next.sv
// Combinational next-value generator shared by single-step and burst paths.
module shift_next
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q_next
);
  always_comb begin
    q_next = q;
    case (mode)
      MODE_HOLD:  q_next = q;
      MODE_LOAD:  q_next = d;
      MODE_SHL:   q_next = {q[WIDTH-2:0], sin_r};
      MODE_SHR:   q_next = {sin_l, q[WIDTH-1:1]};
      MODE_ROTL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_ASR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_CLEAR: q_next = '0;
      default:    q_next = q;
    endcase
  end
endmodule

// File: rtl/param_shift_register.sv
// WIDTH-bit universal register with single-step ops and a counted burst-shift command.
module param_shift_register
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_neg,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, q_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d, amt_clamped;
  logic [2:0]       mode_r_q, mode_r_d, op_mode;

  assign amt_clamped = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;
  // The burst runs on the captured mode; otherwise the live mode drives the op.
  assign op_mode     = (state_q == ST_RUN) ? mode_r_q : mode;

  shift_next #(.WIDTH(WIDTH)) u_next (
    .q      (q_q),
    .mode   (op_mode),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .q_next (q_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      q_q      <= RESET_VAL;
      cnt_q    <= '0;
      mode_r_q <= MODE_HOLD;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      mode_r_q <= mode_r_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    mode_r_d = mode_r_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_r_d = mode;
          cnt_d    = amt_clamped;
          if (is_shift(mode)) begin
            state_d = (amt_clamped != '0) ? ST_RUN : ST_DONE;
          end else begin
            q_d     = q_nxt;
            state_d = ST_DONE;
          end
        end else if (en) begin
          q_d = q_nxt;
        end
      end
      ST_RUN: begin
        q_d   = q_nxt;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign q      = q_q;
  assign q_neg  = ~q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
endmodule

// File: doc/param_shift_register.md
Name: param_shift_register

Overview:
Parametrised successor to the single-bit D flip-flop: a WIDTH-bit universal register with parallel load, shifts, rotates and arithmetic shift. It adds a multi-cycle burst-shift command with a busy/done handshake. It provides complementary outputs (q, q_neg) in the same style as the existing flip-flop. It is the storage and serialisation building block for upcoming serial-link and datapath experiments.

Parameters:
WIDTH, 8, register width in bits (>=2)
RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset
CNT_W, $clog2(WIDTH)+1, width of the burst amount input (derived localparam, not overridable)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
en  in  1  single-step enable; honoured only in IDLE with start=0
mode  in  3  operation select (encoding below)
d  in  WIDTH  parallel load data
sin_l  in  1  serial input entering the MSB on SHR
sin_r  in  1  serial input entering the LSB on SHL
start  in  1  burst request; sampled only in IDLE
amount  in  CNT_W  burst shift count
q  out  WIDTH  register contents
q_neg  out  WIDTH  ~q, combinational
sout_l  out  1  q[WIDTH-1], combinational
sout_r  out  1  q[0], combinational
busy  out  1  high in RUN
done  out  1  one-cycle completion pulse

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Mode encoding:
  - 000 HOLD
  - 001 LOAD (q<=d)
  - 010 SHL (q<={q[W-2:0],sin_r})
  - 011 SHR (q<={sin_l,q[W-1:1]})
  - 100 ROTL
  - 101 ROTR
  - 110 ASR (MSB replicated)
  - 111 CLEAR (q<=0)
- Reset (rst=1 at an edge): q=RESET_VAL, state=IDLE, busy=0, done=0. Reset overrides everything. Reset during RUN aborts the burst, and done does not pulse.
- States: IDLE, RUN, DONE. busy=1 only in RUN. done=1 only in DONE.
- IDLE, start=0, en=1: mode is applied once at the edge; q is visible the next cycle (latency 1). en=0: q holds.
- IDLE, start=1 (takes priority over en):
  - Capture mode into mode_r.
  - cnt = min(amount, WIDTH).
  - Shift/rotate modes (010-110) with cnt>0: go to RUN. No shift occurs on the accepting edge.
  - Shift/rotate modes with cnt=0: go directly to DONE, q unchanged.
  - HOLD/LOAD/CLEAR: the operation is applied once on the accepting edge, then DONE.
- RUN: each edge applies mode_r once and decrements cnt. The edge where cnt==1 moves to DONE. An N-shift burst accepted at edge E0 shifts at E1..EN; done is high between EN and EN+1.
- DONE: lasts one cycle, then IDLE. start and en are ignored in DONE and in RUN; a new burst may be accepted on the edge leaving DONE only after returning to IDLE, i.e. the earliest is the next cycle.
- During a burst, the mode, d and amount inputs are ignored (mode_r is used). sin_l and sin_r are sampled live at every shift edge.
- Rotates by WIDTH return the original value. ASR saturates to all-MSB after WIDTH-1 steps.
- Outputs q_neg, sout_l and sout_r are purely combinational from q, with no extra latency.

Decomposition:
- Shared package shift_reg_pkg:
  - mode localparams: MODE_HOLD..MODE_CLEAR
  - state encoding: ST_IDLE, ST_RUN, ST_DONE
- Sub-module shift_next: purely combinational. Inputs: q, mode, d, sin_l, sin_r. Output: next q. Used by both the single-step and burst paths.
- Top level holds only the FSM, the counter and the register.

Test Plan:
- WIDTH=8, LOAD d=0xA5, en=1 -> next cycle q=0xA5, q_neg=0x5A, sout_l=1, sout_r=1.
- q=0x81, SHL sin_r=1 single step -> q=0x03. Then ASR on q=0x80 -> q=0xC0. CLEAR -> q=0x00.
- q=0x81, start ROTL amount=3 -> busy high for exactly 3 cycles, q=0x0C, then done high 1 cycle, busy=0. en pulses during busy have no effect.
- q=0x81, start ROTR amount=12 -> clamped to 8. busy for 8 cycles, final q=0x81, done pulses once.
- start SHR amount=0 -> no busy, done high the cycle after acceptance, q unchanged.
- q=0x81, burst SHL amount=5 with rst asserted during the 3rd RUN cycle -> next cycle q=0x00, busy=0, and done never asserts.
